// File: rtl/vending_control_param_if.sv
// Signal bundle between the vending controller, the front panel/coin acceptor and the dispenser/hopper.
interface vending_control_param_if #(
   parameter int unsigned N_ITEMS = 4,
   parameter int unsigned MONEY_W = 8,
   parameter int unsigned STOCK_W = 4
);
   localparam int unsigned ITEM_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

   logic               start;
   logic               cancel;
   logic               item_valid;
   logic [ITEM_W-1:0]  item_in;
   logic               coin_valid;
   logic [2:0]         money;
   logic               done_money;
   logic               continue_buy;
   logic               change_ack;
   logic               restock_en;
   logic [ITEM_W-1:0]  restock_item;
   logic [STOCK_W-1:0] restock_qty;
   logic [2:0]         state;
   logic [ITEM_W-1:0]  item_select;
   logic [MONEY_W-1:0] price;
   logic [MONEY_W-1:0] sum_money;
   logic [MONEY_W-1:0] change;
   logic               change_valid;
   logic               out_stock;
   logic               sum_ovf;
   logic               done;
   logic               end_trans;

   modport master (
      output start, cancel, item_valid, item_in, coin_valid, money, done_money,
             continue_buy, change_ack, restock_en, restock_item, restock_qty,
      input  state, item_select, price, sum_money, change, change_valid,
             out_stock, sum_ovf, done, end_trans
   );

   modport slave (
      input  start, cancel, item_valid, item_in, coin_valid, money, done_money,
             continue_buy, change_ack, restock_en, restock_item, restock_qty,
      output state, item_select, price, sum_money, change, change_valid,
             out_stock, sum_ovf, done, end_trans
   );
endinterface

// File: rtl/vending_control_param.sv
// Vending transaction controller: item select with per-item stock, coin accumulation,
// price compare, refund on cancel, and change delivery over a valid/ack handshake.
module vending_control_param #(
   parameter int unsigned N_ITEMS    = 4,
   parameter int unsigned MONEY_W    = 8,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 5,
   parameter int unsigned PRICE_BASE = 10,
   parameter int unsigned PRICE_STEP = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   vending_control_param_if.slave  bus
);
   localparam int unsigned ITEM_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
   localparam int unsigned SUM_W  = MONEY_W + 5;
   localparam int unsigned STK_W  = STOCK_W + 1;
   localparam logic [MONEY_W-1:0] MONEY_MAX = '1;
   localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_SELECT        = 3'd1,
      S_RECEIVE_MONEY = 3'd2,
      S_COMPARE       = 3'd3,
      S_PROCESS       = 3'd4,
      S_RETURN_CHANGE = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [ITEM_W-1:0]  item_q, item_d;
   logic [MONEY_W-1:0] price_q, price_d;
   logic [MONEY_W-1:0] sum_q, sum_d;
   logic [MONEY_W-1:0] change_q, change_d;
   logic               chg_vld_q, chg_vld_d;
   logic               out_stock_q, out_stock_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               end_q, end_d;
   logic               vend_q, vend_d;
   logic [STOCK_W-1:0] stock_q [N_ITEMS];
   logic [STOCK_W-1:0] stock_d [N_ITEMS];
   logic [STK_W-1:0]   stock_net_c [N_ITEMS];

   logic               vend_dec_c;
   logic               item_ok_c;
   logic [4:0]         denom_c;
   logic [SUM_W-1:0]   coin_sum_c;
   logic               add_ovf_c;
   logic [MONEY_W-1:0] sum_add_c;

   // Price table entry, saturated to the money width.
   function automatic logic [MONEY_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
      logic [63:0] p;
      p = 64'(PRICE_BASE) + 64'(idx) * 64'(PRICE_STEP);
      if (p > 64'(MONEY_MAX)) return MONEY_MAX;
      return MONEY_W'(p);
   endfunction

   // Coin decode and saturating add.
   always_comb begin
      denom_c = 5'd0;
      case (bus.money)
         3'b001:  denom_c = 5'd5;
         3'b010:  denom_c = 5'd10;
         3'b100:  denom_c = 5'd20;
         default: denom_c = 5'd0;
      endcase
      coin_sum_c = SUM_W'(sum_q) + SUM_W'(denom_c);
      add_ovf_c  = coin_sum_c > SUM_W'(MONEY_MAX);
      sum_add_c  = add_ovf_c ? MONEY_MAX : MONEY_W'(coin_sum_c);
   end

   assign item_ok_c = (32'(bus.item_in) < N_ITEMS) && (stock_q[bus.item_in] != '0);

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      item_d      = item_q;
      price_d     = price_q;
      sum_d       = sum_q;
      change_d    = change_q;
      chg_vld_d   = chg_vld_q;
      ovf_d       = ovf_q;
      vend_d      = vend_q;
      out_stock_d = 1'b0;
      done_d      = 1'b0;
      end_d       = 1'b0;
      vend_dec_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else if (bus.item_valid) begin
               if (item_ok_c) begin
                  item_d  = bus.item_in;
                  price_d = price_of(bus.item_in);
                  state_d = S_RECEIVE_MONEY;
               end else begin
                  out_stock_d = 1'b1;
               end
            end
         end
         S_RECEIVE_MONEY: begin
            if (bus.coin_valid) begin
               sum_d = sum_add_c;
               if (add_ovf_c) ovf_d = 1'b1;
            end
            if (bus.cancel) begin
               vend_d    = 1'b0;
               change_d  = sum_d;
               chg_vld_d = (sum_d != '0);
               state_d   = S_RETURN_CHANGE;
            end else if (bus.done_money) begin
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (sum_q >= price_q) begin
               vend_d     = 1'b1;
               vend_dec_c = 1'b1;
               change_d   = sum_q - price_q;
               chg_vld_d  = (sum_q != price_q);
               state_d    = S_RETURN_CHANGE;
            end else begin
               state_d = S_PROCESS;
            end
         end
         S_PROCESS: begin
            if (bus.cancel) begin
               vend_d    = 1'b0;
               change_d  = sum_q;
               chg_vld_d = (sum_q != '0);
               state_d   = S_RETURN_CHANGE;
            end else begin
               state_d = S_RECEIVE_MONEY;
            end
         end
         S_RETURN_CHANGE: begin
            if (!chg_vld_q || bus.change_ack) begin
               done_d    = vend_q;
               end_d     = 1'b1;
               sum_d     = '0;
               price_d   = '0;
               change_d  = '0;
               chg_vld_d = 1'b0;
               ovf_d     = 1'b0;
               vend_d    = 1'b0;
               state_d   = bus.continue_buy ? S_SELECT : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stock update: restock add and vend decrement combine before saturating.
   always_comb begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         stock_net_c[i] = {1'b0, stock_q[i]};
         if (bus.restock_en && (32'(bus.restock_item) == i))
            stock_net_c[i] = stock_net_c[i] + STK_W'(bus.restock_qty);
         if (vend_dec_c && (32'(item_q) == i))
            stock_net_c[i] = stock_net_c[i] - STK_W'(1);
         stock_d[i] = (stock_net_c[i] > STK_W'(STOCK_MAX)) ? STOCK_MAX : STOCK_W'(stock_net_c[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         item_q      <= '0;
         price_q     <= '0;
         sum_q       <= '0;
         change_q    <= '0;
         chg_vld_q   <= 1'b0;
         out_stock_q <= 1'b0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
         end_q       <= 1'b0;
         vend_q      <= 1'b0;
         for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         state_q     <= state_d;
         item_q      <= item_d;
         price_q     <= price_d;
         sum_q       <= sum_d;
         change_q    <= change_d;
         chg_vld_q   <= chg_vld_d;
         out_stock_q <= out_stock_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
         end_q       <= end_d;
         vend_q      <= vend_d;
         for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
      end
   end

   assign bus.state        = state_q;
   assign bus.item_select  = item_q;
   assign bus.price        = price_q;
   assign bus.sum_money    = sum_q;
   assign bus.change       = change_q;
   assign bus.change_valid = chg_vld_q;
   assign bus.out_stock    = out_stock_q;
   assign bus.sum_ovf      = ovf_q;
   assign bus.done         = done_q;
   assign bus.end_trans    = end_q;
endmodule

// File: tb/tb_vending_control_param.sv
// Directed self-checking bench for vending_control_param: vector table plus hand-written corner sequences.
module tb_vending_control_param;
   localparam int unsigned N_ITEMS = 4;
   localparam int unsigned MONEY_W = 8;
   localparam int unsigned STOCK_W = 4;
   localparam int unsigned ITEM_W  = 2;

   localparam int OP_NONE = 0, OP_START = 1, OP_ITEM = 2, OP_COIN = 3,
                  OP_DONE = 4, OP_ACK = 5, OP_CONT = 6, OP_CANCEL = 7;

   typedef struct {
      int op;   int arg;
      int st;   int pr;  int sm;  int ch;  int cv;  int dn;  int et;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs [21];

   always #5 clk = ~clk;

   vending_control_param_if #(.N_ITEMS(N_ITEMS), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W)) bus ();

   vending_control_param #(
      .N_ITEMS(N_ITEMS), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W),
      .STOCK_INIT(5), .PRICE_BASE(10), .PRICE_STEP(5)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.start = 1'b0;  bus.cancel = 1'b0;  bus.item_valid = 1'b0;  bus.item_in = '0;
      bus.coin_valid = 1'b0;  bus.money = '0;  bus.done_money = 1'b0;
      bus.continue_buy = 1'b0;  bus.change_ack = 1'b0;
      bus.restock_en = 1'b0;  bus.restock_item = '0;  bus.restock_qty = '0;
   endtask

   task automatic check_outs(input string tag, input int st, input int pr, input int sm,
                             input int ch, input int cv, input int dn, input int et);
      check($sformatf("%s.state", tag),        int'(bus.state),        st);
      check($sformatf("%s.price", tag),        int'(bus.price),        pr);
      check($sformatf("%s.sum_money", tag),    int'(bus.sum_money),    sm);
      check($sformatf("%s.change", tag),       int'(bus.change),       ch);
      check($sformatf("%s.change_valid", tag), int'(bus.change_valid), cv);
      check($sformatf("%s.done", tag),         int'(bus.done),         dn);
      check($sformatf("%s.end_trans", tag),    int'(bus.end_trans),    et);
   endtask

   task automatic apply(input vec_t v);
      clear_in();
      case (v.op)
         OP_START:  bus.start = 1'b1;
         OP_ITEM:   begin bus.item_valid = 1'b1; bus.item_in = ITEM_W'(v.arg); end
         OP_COIN:   begin bus.coin_valid = 1'b1; bus.money = 3'(v.arg); end
         OP_DONE:   bus.done_money = 1'b1;
         OP_ACK:    begin bus.change_ack = 1'b1; bus.continue_buy = 1'(v.arg); end
         OP_CONT:   bus.continue_buy = 1'b1;
         OP_CANCEL: bus.cancel = 1'b1;
         default:   ;
      endcase
   endtask

   task automatic coin(input logic [2:0] code);
      clear_in();
      bus.coin_valid = 1'b1;
      bus.money = code;
      step();
   endtask

   initial begin
      // Item 1 (price 15) paid with 10+10, change held until ack; then item 3 via PROCESS loop.
      vecs[0]  = '{OP_START,  0, 1, 0,  0,  0, 0, 0, 0};
      vecs[1]  = '{OP_ITEM,   1, 2, 15, 0,  0, 0, 0, 0};
      vecs[2]  = '{OP_COIN,   2, 2, 15, 10, 0, 0, 0, 0};
      vecs[3]  = '{OP_COIN,   2, 2, 15, 20, 0, 0, 0, 0};
      vecs[4]  = '{OP_DONE,   0, 3, 15, 20, 0, 0, 0, 0};
      vecs[5]  = '{OP_NONE,   0, 5, 15, 20, 5, 1, 0, 0};
      vecs[6]  = '{OP_NONE,   0, 5, 15, 20, 5, 1, 0, 0};
      vecs[7]  = '{OP_NONE,   0, 5, 15, 20, 5, 1, 0, 0};
      vecs[8]  = '{OP_ACK,    0, 0, 0,  0,  0, 0, 1, 1};
      vecs[9]  = '{OP_COIN,   4, 0, 0,  0,  0, 0, 0, 0};
      vecs[10] = '{OP_START,  0, 1, 0,  0,  0, 0, 0, 0};
      vecs[11] = '{OP_ITEM,   3, 2, 25, 0,  0, 0, 0, 0};
      vecs[12] = '{OP_COIN,   4, 2, 25, 20, 0, 0, 0, 0};
      vecs[13] = '{OP_DONE,   0, 3, 25, 20, 0, 0, 0, 0};
      vecs[14] = '{OP_NONE,   0, 4, 25, 20, 0, 0, 0, 0};
      vecs[15] = '{OP_NONE,   0, 2, 25, 20, 0, 0, 0, 0};
      vecs[16] = '{OP_COIN,   1, 2, 25, 25, 0, 0, 0, 0};
      vecs[17] = '{OP_DONE,   0, 3, 25, 25, 0, 0, 0, 0};
      vecs[18] = '{OP_NONE,   0, 5, 25, 25, 0, 0, 0, 0};
      vecs[19] = '{OP_CONT,   0, 1, 0,  0,  0, 0, 1, 1};
      vecs[20] = '{OP_CANCEL, 0, 0, 0,  0,  0, 0, 0, 0};

      clear_in();
      reset_n = 1'b0;
      repeat (2) step();
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) check($sformatf("reset.stock%0d", i), int'(dut.stock_q[i]), 5);
      reset_n = 1'b1;
      step();

      // Reset mid-transaction discards the accumulated 15.
      apply('{OP_START, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      apply('{OP_ITEM,  0, 0, 0, 0, 0, 0, 0, 0}); step();
      coin(3'b001);
      coin(3'b010);
      check("midrst.pre_sum", int'(bus.sum_money), 15);
      check("midrst.pre_state", int'(bus.state), 2);
      clear_in();
      #2 reset_n = 1'b0;
      #1;
      check_outs("midrst", 0, 0, 0, 0, 0, 0, 0);
      check("midrst.sum_ovf", int'(bus.sum_ovf), 0);
      check("midrst.out_stock", int'(bus.out_stock), 0);
      for (int i = 0; i < 4; i++) check($sformatf("midrst.stock%0d", i), int'(dut.stock_q[i]), 5);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 21; i++) begin
         apply(vecs[i]);
         step();
         check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].sm,
                    vecs[i].ch, vecs[i].cv, vecs[i].dn, vecs[i].et);
      end
      check("item_select_kept", int'(bus.item_select), 3);
      check("stock1_after_vend", int'(dut.stock_q[1]), 4);
      check("stock3_after_vend", int'(dut.stock_q[3]), 4);

      // Drain item 2 (price 20) with exact payment, then hit out of stock.
      apply('{OP_START, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      for (int k = 0; k < 5; k++) begin
         apply('{OP_ITEM, 2, 0, 0, 0, 0, 0, 0, 0}); step();
         coin(3'b100);
         apply('{OP_DONE, 0, 0, 0, 0, 0, 0, 0, 0}); step();
         clear_in(); step();
         check($sformatf("drain%0d.cv", k), int'(bus.change_valid), 0);
         apply('{OP_CONT, 0, 0, 0, 0, 0, 0, 0, 0}); step();
         check($sformatf("drain%0d.done", k), int'(bus.done), 1);
         check($sformatf("drain%0d.state", k), int'(bus.state), 1);
      end
      apply('{OP_ITEM, 2, 0, 0, 0, 0, 0, 0, 0}); step();
      check("oos.out_stock", int'(bus.out_stock), 1);
      check("oos.state", int'(bus.state), 1);
      clear_in(); step();
      check("oos.pulse_end", int'(bus.out_stock), 0);
      apply('{OP_CANCEL, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      check("oos.cancel_state", int'(bus.state), 0);
      check("oos.cancel_end", int'(bus.end_trans), 0);

      // Refund: cancel beats done_money in the same cycle.
      apply('{OP_START, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      apply('{OP_ITEM,  0, 0, 0, 0, 0, 0, 0, 0}); step();
      coin(3'b001);
      clear_in(); bus.cancel = 1'b1; bus.done_money = 1'b1; step();
      check_outs("refund", 5, 10, 5, 5, 1, 0, 0);
      clear_in(); step();
      check("refund.hold_cv", int'(bus.change_valid), 1);
      apply('{OP_ACK, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      check_outs("refund.exit", 0, 0, 0, 0, 0, 0, 1);

      // Saturating coin sum, restock saturation, and restock coinciding with a vend.
      apply('{OP_START, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      apply('{OP_ITEM,  0, 0, 0, 0, 0, 0, 0, 0}); step();
      for (int k = 0; k < 13; k++) begin
         coin(3'b100);
         if (k == 11) begin
            check("ovf.sum240", int'(bus.sum_money), 240);
            check("ovf.flag_clear", int'(bus.sum_ovf), 0);
         end
      end
      check("ovf.sum_sat", int'(bus.sum_money), 255);
      check("ovf.flag_set", int'(bus.sum_ovf), 1);
      clear_in(); bus.restock_en = 1'b1; bus.restock_item = 2'd0; bus.restock_qty = 4'd15; step();
      check("restock.sat", int'(dut.stock_q[0]), 15);
      apply('{OP_DONE, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      clear_in(); bus.restock_en = 1'b1; bus.restock_item = 2'd0; bus.restock_qty = 4'd1; step();
      check_outs("ovf.vend", 5, 10, 255, 245, 1, 0, 0);
      check("restock.net", int'(dut.stock_q[0]), 15);
      check("ovf.sticky", int'(bus.sum_ovf), 1);
      apply('{OP_ACK, 0, 0, 0, 0, 0, 0, 0, 0}); step();
      check_outs("ovf.exit", 0, 0, 0, 0, 0, 1, 1);
      check("ovf.cleared", int'(bus.sum_ovf), 0);
      clear_in(); bus.restock_en = 1'b1; bus.restock_item = 2'd1; bus.restock_qty = 4'd3; step();
      check("restock.idle", int'(dut.stock_q[1]), 7);
      clear_in(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
